// File: rtl/mem_resp_pkg.sv
// Shared types for the memory responder: FSM states, operation encoding
// and the width of the optional statistics counters.
package mem_resp_pkg;

   localparam int STAT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      DONE
   } state_t;

   typedef enum logic {
      OP_RD,
      OP_WR
   } op_t;

endpackage

// File: rtl/mem_responder_ram_array.sv
// Single-port synchronous RAM, DATA_W x DEPTH, with registered read data.
// Contents are deliberately not reset.
module ram_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512,
   parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write when enabled and read the addressed word every cycle
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata <= mem_q[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR bus: captures a read or write
// request, waits WAIT_CYCLES, performs one RAM access and pulses done.
// Optional build macro MEM_RESP_STATS_EN adds saturating read/write
// counters (rd_count, wr_count) for successful accesses.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 512,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              read,
   input  logic              wren,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              done,
   output logic              err
`ifdef MEM_RESP_STATS_EN
   ,
   output logic [STAT_W-1:0] rd_count,
   output logic [STAT_W-1:0] wr_count
`endif
);

   localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_V   = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]       WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t              state_q, state_d;
   op_t                 op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          wait_q, wait_d;
   logic                armed_q, armed_d;
   logic                err_pend_q, err_pend_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                in_range;
   logic                ram_we;
   logic [DATA_W-1:0]   ram_rdata;

   assign in_range = ({1'b0, addr_q} < DEPTH_V);

   // The RAM is addressed with the next-cycle address so that the word is
   // already in rdata when ACCESS is reached, even with zero wait states.
   ram_array #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk  (Clock),
      .we   (ram_we),
      .addr (addr_d[IDX_W-1:0]),
      .wdata(wdata_q),
      .rdata(ram_rdata)
   );

   // Next-state, capture, error and output logic for the request FSM
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wait_d     = wait_q;
      armed_d    = armed_q;
      err_pend_d = err_pend_q;
      data_out_d = data_out_q;
      ram_we     = 1'b0;

      if (!read && !wren) begin
         armed_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (armed_q) begin
               if (read && wren) begin
                  err_pend_d = 1'b1;
                  armed_d    = 1'b0;
                  state_d    = DONE;
               end else if (read || wren) begin
                  addr_d     = addr;
                  wdata_d    = data_in;
                  op_d       = wren ? OP_WR : OP_RD;
                  err_pend_d = 1'b0;
                  wait_d     = 4'd0;
                  state_d    = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
               end
            end
         end
         WAIT: begin
            if (wait_q == WAIT_LAST) begin
               state_d = ACCESS;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         ACCESS: begin
            err_pend_d = !in_range;
            armed_d    = 1'b0;
            state_d    = DONE;
            if (op_q == OP_WR) begin
               ram_we = in_range;
            end else begin
               data_out_d = in_range ? ram_rdata : '0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE) || (state_q == DONE);
      done_d = (state_q == DONE);
      err_d  = (state_q == DONE) && err_pend_q;
   end

   // State, capture and output registers with asynchronous reset
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         op_q       <= OP_RD;
         addr_q     <= '0;
         wdata_q    <= '0;
         wait_q     <= 4'd0;
         armed_q    <= 1'b1;
         err_pend_q <= 1'b0;
         data_out_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wait_q     <= wait_d;
         armed_q    <= armed_d;
         err_pend_q <= err_pend_d;
         data_out_q <= data_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign data_out = data_out_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

`ifdef MEM_RESP_STATS_EN
   logic [STAT_W-1:0] rd_count_q, rd_count_d;
   logic [STAT_W-1:0] wr_count_q, wr_count_d;

   // Count successful accesses at the ACCESS edge, saturating at all-ones
   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (state_q == ACCESS && in_range) begin
         if (op_q == OP_RD && rd_count_q != '1) begin
            rd_count_d = rd_count_q + STAT_W'(1);
         end
         if (op_q == OP_WR && wr_count_q != '1) begin
            wr_count_d = wr_count_q + STAT_W'(1);
         end
      end
   end

   // Statistics counter registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`else
   // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder. Instance 0: DEPTH=256, WAIT_CYCLES=1.
// Instance 1: DEPTH=512, WAIT_CYCLES=0 (statistics checked when
// MEM_RESP_STATS_EN is defined).
module tb_mem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  read_s = '0;
   logic [1:0]  wren_s = '0;
   logic [8:0]  addr_s [2];
   logic [31:0] din_s  [2];
   logic [31:0] dout_s [2];
   logic [1:0]  busy_s;
   logic [1:0]  done_s;
   logic [1:0]  err_s;
`ifdef MEM_RESP_STATS_EN
   logic [15:0] rdc_s [2];
   logic [15:0] wrc_s [2];
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   mem_responder #(
      .ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(1)
   ) dut_a (
      .Clock(clock), .Reset(reset),
      .read(read_s[0]), .wren(wren_s[0]),
      .addr(addr_s[0]), .data_in(din_s[0]),
      .data_out(dout_s[0]), .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0])
`ifdef MEM_RESP_STATS_EN
      , .rd_count(rdc_s[0]), .wr_count(wrc_s[0])
`endif
   );

   mem_responder #(
      .ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(0)
   ) dut_b (
      .Clock(clock), .Reset(reset),
      .read(read_s[1]), .wren(wren_s[1]),
      .addr(addr_s[1]), .data_in(din_s[1]),
      .data_out(dout_s[1]), .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1])
`ifdef MEM_RESP_STATS_EN
      , .rd_count(rdc_s[1]), .wr_count(wrc_s[1])
`endif
   );

   // Issue one request on instance u and measure edges from capture to done.
   // lat = -1 means done never arrived within the cycle budget.
   task automatic applyStimulus(input int u, input logic rd, input logic wr,
                                input logic [8:0] a, input logic [31:0] d,
                                output int lat, output logic e);
      @(negedge clock);
      read_s[u] = rd;
      wren_s[u] = wr;
      addr_s[u] = a;
      din_s[u]  = d;
      @(posedge clock);
      lat = -1;
      e   = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (k == 1) begin
            addr_s[u] = 9'h1FF;
            din_s[u]  = 32'hFFFF_FFFF;
         end
         if (done_s[u]) begin
            lat = k - 1;
            e   = err_s[u];
            break;
         end
      end
      read_s[u] = 1'b0;
      wren_s[u] = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      compared++; if (dout_s[0] !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_dout_a: got %h expected %h", dout_s[0], 32'h0); end
      compared++; if (busy_s !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_busy: got %b expected %b", busy_s, 2'b00); end
      compared++; if (done_s !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_done: got %b expected %b", done_s, 2'b00); end
      compared++; if (err_s !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_err: got %b expected %b", err_s, 2'b00); end
      compared++; if (dout_s[1] !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_dout_b: got %h expected %h", dout_s[1], 32'h0); end
`ifdef MEM_RESP_STATS_EN
      compared++; if (rdc_s[0] !== 16'h0 || wrc_s[0] !== 16'h0) begin mismatched++; $display("[TB] FAIL rst_stats: got %h/%h expected 0/0", rdc_s[0], wrc_s[0]); end
`endif
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_write_read();
      int lat; logic e;
      applyStimulus(0, 1'b0, 1'b1, 9'd5, 32'hDEAD_BEEF, lat, e);
      compared++; if (lat !== 3) begin mismatched++; $display("[TB] FAIL wr_latency: got %0d expected %0d", lat, 3); end
      compared++; if (e !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_err: got %b expected %b", e, 1'b0); end
      compared++; if (dout_s[0] !== 32'h0) begin mismatched++; $display("[TB] FAIL wr_keeps_dout: got %h expected %h", dout_s[0], 32'h0); end
      applyStimulus(0, 1'b1, 1'b0, 9'd5, 32'h0, lat, e);
      compared++; if (lat !== 3) begin mismatched++; $display("[TB] FAIL rd_latency: got %0d expected %0d", lat, 3); end
      compared++; if (e !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_err: got %b expected %b", e, 1'b0); end
      compared++; if (dout_s[0] !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL rd_data: got %h expected %h", dout_s[0], 32'hDEAD_BEEF); end
      applyStimulus(0, 1'b0, 1'b1, 9'd6, 32'h0BAD_F00D, lat, e);
      compared++; if (dout_s[0] !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL wr2_keeps_dout: got %h expected %h", dout_s[0], 32'hDEAD_BEEF); end
   endtask

   task automatic test_held_strobe();
      int pulses;
      @(negedge clock);
      read_s[0] = 1'b1;
      addr_s[0] = 9'd6;
      pulses = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clock);
         if (done_s[0]) pulses++;
      end
      compared++; if (pulses !== 1) begin mismatched++; $display("[TB] FAIL held_single_done: got %0d expected %0d", pulses, 1); end
      compared++; if (dout_s[0] !== 32'h0BAD_F00D) begin mismatched++; $display("[TB] FAIL held_data: got %h expected %h", dout_s[0], 32'h0BAD_F00D); end
      read_s[0] = 1'b0;
      @(negedge clock);
      read_s[0] = 1'b1;
      addr_s[0] = 9'd5;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (done_s[0]) pulses++;
      end
      compared++; if (pulses !== 1) begin mismatched++; $display("[TB] FAIL rearm_done: got %0d expected %0d", pulses, 1); end
      compared++; if (dout_s[0] !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL rearm_data: got %h expected %h", dout_s[0], 32'hDEAD_BEEF); end
      read_s[0] = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_simultaneous();
      int lat; logic e;
      applyStimulus(0, 1'b1, 1'b1, 9'd5, 32'h1111_1111, lat, e);
      compared++; if (lat !== 1) begin mismatched++; $display("[TB] FAIL both_latency: got %0d expected %0d", lat, 1); end
      compared++; if (e !== 1'b1) begin mismatched++; $display("[TB] FAIL both_err: got %b expected %b", e, 1'b1); end
      compared++; if (dout_s[0] !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL both_dout: got %h expected %h", dout_s[0], 32'hDEAD_BEEF); end
      applyStimulus(0, 1'b1, 1'b0, 9'd5, 32'h0, lat, e);
      compared++; if (dout_s[0] !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL both_ram_kept: got %h expected %h", dout_s[0], 32'hDEAD_BEEF); end
   endtask

   task automatic test_out_of_range();
      int lat; logic e;
      applyStimulus(0, 1'b0, 1'b1, 9'd44, 32'hA5A5_A5A5, lat, e);
      applyStimulus(0, 1'b0, 1'b1, 9'd300, 32'hCAFE_F00D, lat, e);
      compared++; if (lat !== 3) begin mismatched++; $display("[TB] FAIL oor_wr_latency: got %0d expected %0d", lat, 3); end
      compared++; if (e !== 1'b1) begin mismatched++; $display("[TB] FAIL oor_wr_err: got %b expected %b", e, 1'b1); end
      applyStimulus(0, 1'b1, 1'b0, 9'd44, 32'h0, lat, e);
      compared++; if (dout_s[0] !== 32'hA5A5_A5A5) begin mismatched++; $display("[TB] FAIL no_alias_pre: got %h expected %h", dout_s[0], 32'hA5A5_A5A5); end
      applyStimulus(0, 1'b1, 1'b0, 9'd300, 32'h0, lat, e);
      compared++; if (e !== 1'b1) begin mismatched++; $display("[TB] FAIL oor_rd_err: got %b expected %b", e, 1'b1); end
      compared++; if (dout_s[0] !== 32'h0) begin mismatched++; $display("[TB] FAIL oor_rd_data: got %h expected %h", dout_s[0], 32'h0); end
      applyStimulus(0, 1'b1, 1'b0, 9'd44, 32'h0, lat, e);
      compared++; if (e !== 1'b0) begin mismatched++; $display("[TB] FAIL rd44_err: got %b expected %b", e, 1'b0); end
      compared++; if (dout_s[0] !== 32'hA5A5_A5A5) begin mismatched++; $display("[TB] FAIL no_alias_post: got %h expected %h", dout_s[0], 32'hA5A5_A5A5); end
   endtask

   task automatic test_reset_mid_write();
      int lat; logic e;
      applyStimulus(0, 1'b0, 1'b1, 9'd7, 32'h0, lat, e);
      @(negedge clock);
      wren_s[0] = 1'b1;
      addr_s[0] = 9'd7;
      din_s[0]  = 32'h1234_5678;
      @(posedge clock);
      @(negedge clock);
      compared++; if (busy_s[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_busy_before: got %b expected %b", busy_s[0], 1'b1); end
      reset = 1'b1;
      #1;
      compared++; if (busy_s[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_busy_after: got %b expected %b", busy_s[0], 1'b0); end
      compared++; if (done_s[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_done_after: got %b expected %b", done_s[0], 1'b0); end
      wren_s[0] = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      applyStimulus(0, 1'b1, 1'b0, 9'd7, 32'h0, lat, e);
      compared++; if (lat !== 3) begin mismatched++; $display("[TB] FAIL mid_rd_latency: got %0d expected %0d", lat, 3); end
      compared++; if (dout_s[0] !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_not_committed: got %h expected %h", dout_s[0], 32'h0); end
   endtask

   task automatic test_zero_wait();
      int lat; logic e;
      logic [8:0]  a_tab [5] = '{9'd10, 9'd11, 9'd10, 9'd11, 9'd10};
      logic [31:0] d_tab [5] = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 32'h0};
      logic        w_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] x_tab [5] = '{32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h1111_1111};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, !w_tab[i], w_tab[i], a_tab[i], d_tab[i], lat, e);
         compared++; if (lat !== 2) begin mismatched++; $display("[TB] FAIL w0_latency[%0d]: got %0d expected %0d", i, lat, 2); end
         compared++; if (dout_s[1] !== x_tab[i]) begin mismatched++; $display("[TB] FAIL w0_data[%0d]: got %h expected %h", i, dout_s[1], x_tab[i]); end
      end
      applyStimulus(1, 1'b1, 1'b1, 9'd10, 32'h0, lat, e);
      compared++; if (lat !== 1 || e !== 1'b1) begin mismatched++; $display("[TB] FAIL w0_illegal: got lat %0d err %b expected lat 1 err 1", lat, e); end
`ifdef MEM_RESP_STATS_EN
      compared++; if (rdc_s[1] !== 16'd3) begin mismatched++; $display("[TB] FAIL rd_count: got %0d expected %0d", rdc_s[1], 3); end
      compared++; if (wrc_s[1] !== 16'd2) begin mismatched++; $display("[TB] FAIL wr_count: got %0d expected %0d", wrc_s[1], 2); end
`endif
   endtask

   initial begin
      addr_s[0] = '0; addr_s[1] = '0;
      din_s[0]  = '0; din_s[1]  = '0;
      test_reset();
      test_write_read();
      test_held_strobe();
      test_simultaneous();
      test_out_of_range();
      test_reset_mid_write();
      test_zero_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
